rs_alu_multi: RTL and testbench
===============================

# rs_alu_multi

Parametrised ALU reservation station with configurable depth and CDB port count. Holds issued ALU ops until both operands are captured, selects the oldest ready entry each cycle, and hands it to the ALU through a valid/ready output register. It sits between the issue stage and the ALU, snooping every CDB port, and is cleared by ROB rollback.

## Interface
- ENTRIES, 4: number of RS entries (2..16)
- NCDB, 2: number of CDB broadcast ports
- ROB_W, 4: ROB tag width; tag 0 means "no producer / value present"
- DATA_W, 32: operand width
- OP_W, 4: ALU op width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rollback  in  1  synchronous flush of all entries and output register
- issue_valid  in  1  issue request
- issue_ready  out  1  = !full
- issue_op  in  OP_W  ALU op
- issue_vj / issue_vk  in  DATA_W  operand values (meaningful when matching Q is 0)
- issue_qj / issue_qk  in  ROB_W  producer tags
- issue_dest  in  ROB_W  destination ROB tag
- cdb_tag  in  NCDB*ROB_W  per-port broadcast tag, port p at [p*ROB_W +: ROB_W]; 0 = idle
- cdb_data  in  NCDB*DATA_W  per-port data
- full  out  1  all entries busy
- count  out  clog2(ENTRIES+1)  busy entries
- ex_valid  out  1  dispatch register holds an op
- ex_ready  in  1  ALU accepts
- ex_op / ex_vj / ex_vk / ex_dest  out  OP_W/DATA_W/DATA_W/ROB_W  dispatched op

## Operation
- Entry state: busy, op, vj, vk, qj, qk, dest; age matrix of ENTRIES×ENTRIES bits.
- Allocate: on issue_valid && issue_ready, write lowest-index free entry; set its age column (older-than bits) for every busy entry, clear its row.
- Issue bypass: if issue_qj/qk matches a non-zero cdb_tag in the same cycle, store that CDB data and Q=0.
- Wakeup: every busy entry compares qj, qk against all NCDB tags; match → capture data, Q←0. Multiple ports same tag: lowest port wins.
- Ready = busy && qj==0 && qk==0 (registered Q only; entry woken this cycle is ready next cycle).
- Select: ready entry with no older ready entry (oldest-first).
- Dispatch register loads when !ex_valid || ex_ready: if a ready entry exists, load it, ex_valid←1, clear its busy; else ex_valid←0. Otherwise holds unchanged (contents stable while ex_valid && !ex_ready).
- Slot freed by dispatch is not allocatable until next cycle; full does not look ahead.
- rollback: all busy←0, ex_valid←0, age matrix cleared; overrides issue, wakeup, dispatch same cycle.
- issue_valid while full: ignored, no state change.

## Timing
- Reset (async): all busy=0, full=0, count=0, issue_ready=1, ex_valid=0, ex_op/vj/vk/dest=0, age matrix=0.
- Issue with both Q=0 at edge N → ex_valid high after edge N+1 (1-cycle latency).
- CDB wakeup at edge M → dispatch earliest after edge M+1.
- full, issue_ready, count: combinational from registered busy.
- Throughput: one dispatch per cycle while ex_ready=1.

## Structure
- Shared defines header: ROB tag null (0), default ROB_W/DATA_W/OP_W, ALU op encodings.
- Sub-module rs_age_matrix: allocation update, dealloc, oldest-of-request-vector select (one-hot grant); reused by future RS variants.
- Top holds entry storage, CDB compare, allocate priority encoder, dispatch register.

## Test plan
- Reset mid-stream: fill 3 entries, assert rst asynchronously → busy=0, count=0, ex_valid=0 immediately.
- Ready issue: op=ADD, vj=5, vk=7, Q=0, dest=3 at N → ex_valid, ex_vj=5, ex_vk=7, ex_dest=3 after N+1.
- Oldest-first: issue A(qj=2), B(qj=2), C ready; broadcast tag 2 data 0x10 on port 1 → C dispatches first, then A, then B; A/B vj=0x10.
- Bypass + dual CDB: issue qj=4, qk=5 while cdb port0 tag4=0xAA, port1 tag5=0xBB → entry ready next cycle, dispatches vj=0xAA, vk=0xBB.
- Backpressure/full: ENTRIES=4, ex_ready=0, issue 5 ready ops → first in dispatch reg held stable, remaining 4 fill, issue_ready=0, 6th ignored; raise ex_ready → one dispatch per cycle in issue order.
- Rollback with issue_valid and CDB hit same cycle → all empty, ex_valid=0, count=0 next cycle.

Source files
------------

// File: rtl/rs_alu_multi_pkg.sv
// Shared definitions for the ALU reservation station slice: null ROB tag,
// default bus widths and ALU op encodings.
package rs_alu_multi_pkg;

    localparam int ROB_NULL   = 0;
    localparam int DEF_ROB_W  = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_OP_W   = 4;

    typedef enum logic [DEF_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/rs_alu_multi_if.sv
// Issue-side and ALU-side handshake bundle of the reservation station.
interface rs_alu_multi_if
    import rs_alu_multi_pkg::*;
#(
    parameter int ROB_W  = DEF_ROB_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W
) ();

    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;
    logic [ROB_W-1:0]  issue_qj;
    logic [ROB_W-1:0]  issue_qk;
    logic [ROB_W-1:0]  issue_dest;

    logic              ex_valid;
    logic              ex_ready;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_vj;
    logic [DATA_W-1:0] ex_vk;
    logic [ROB_W-1:0]  ex_dest;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk, issue_dest,
        output ex_ready,
        input  issue_ready,
        input  ex_valid, ex_op, ex_vj, ex_vk, ex_dest
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk, issue_dest,
        input  ex_ready,
        output issue_ready,
        output ex_valid, ex_op, ex_vj, ex_vk, ex_dest
    );

endinterface

// File: rtl/rs_alu_multi_age_matrix.sv
// Age matrix for reservation stations: tracks relative entry age and grants
// the oldest requester as a one-hot vector.
module rs_age_matrix
    import rs_alu_multi_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         alloc_en,
    input  logic [N-1:0] alloc_oh,
    input  logic [N-1:0] valid,
    input  logic [N-1:0] dealloc,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    // older[i][j] set means entry i was allocated before entry j
    logic [N-1:0] older [N];

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < N; i++) begin
            grant[i] = req[i];
            for (int unsigned j = 0; j < N; j++) begin
                if (req[j] && older[j][i]) grant[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) older[i] <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < N; i++) older[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (alloc_en && alloc_oh[i])
                        older[i][j] <= 1'b0;
                    else if (alloc_en && alloc_oh[j])
                        older[i][j] <= valid[i] && !dealloc[i];
                    else if (dealloc[i] || dealloc[j])
                        older[i][j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rs_alu_multi.sv
// ALU reservation station: holds issued ops until both operands arrive via
// the CDB, then dispatches the oldest ready entry through a valid/ready register.
module rs_alu_multi
    import rs_alu_multi_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int NCDB    = 2,
    parameter int ROB_W   = DEF_ROB_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OP_W    = DEF_OP_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rollback,
    rs_alu_multi_if.slave                bus,
    input  logic [NCDB*ROB_W-1:0]        cdb_tag,
    input  logic [NCDB*DATA_W-1:0]       cdb_data,
    output logic                         full,
    output logic [$clog2(ENTRIES+1)-1:0] count
);

    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] busy;
    logic [OP_W-1:0]    op_q   [ENTRIES];
    logic [DATA_W-1:0]  vj_q   [ENTRIES];
    logic [DATA_W-1:0]  vk_q   [ENTRIES];
    logic [ROB_W-1:0]   qj_q   [ENTRIES];
    logic [ROB_W-1:0]   qk_q   [ENTRIES];
    logic [ROB_W-1:0]   dest_q [ENTRIES];

    logic              ex_valid_q;
    logic [OP_W-1:0]   ex_op_q;
    logic [DATA_W-1:0] ex_vj_q;
    logic [DATA_W-1:0] ex_vk_q;
    logic [ROB_W-1:0]  ex_dest_q;

    logic [DATA_W:0]    wake_j [ENTRIES];
    logic [DATA_W:0]    wake_k [ENTRIES];
    logic [DATA_W:0]    byp_j, byp_k;
    logic [ENTRIES-1:0] ready, grant, alloc_oh, dealloc;
    logic [IDX_W-1:0]   alloc_idx, grant_idx;
    logic               alloc_en, disp_load, disp_take;

    // MSB flags a hit; lowest-numbered matching port supplies the data
    function automatic logic [DATA_W:0] snoop(input logic [ROB_W-1:0]       q,
                                              input logic [NCDB*ROB_W-1:0]  tags,
                                              input logic [NCDB*DATA_W-1:0] data);
        logic [DATA_W:0] r;
        r = '0;
        if (q != ROB_W'(ROB_NULL)) begin
            for (int unsigned p = 0; p < NCDB; p++) begin
                if (!r[DATA_W] && tags[p*ROB_W +: ROB_W] == q)
                    r = {1'b1, data[p*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            wake_j[i] = snoop(qj_q[i], cdb_tag, cdb_data);
            wake_k[i] = snoop(qk_q[i], cdb_tag, cdb_data);
        end
        byp_j = snoop(bus.issue_qj, cdb_tag, cdb_data);
        byp_k = snoop(bus.issue_qk, cdb_tag, cdb_data);
    end

    always_comb begin
        ready     = '0;
        alloc_oh  = '0;
        alloc_idx = '0;
        count     = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            ready[i] = busy[i] && qj_q[i] == ROB_W'(ROB_NULL) && qk_q[i] == ROB_W'(ROB_NULL);
            count    = count + CNT_W'(busy[i]);
            if (!busy[i] && alloc_oh == '0) begin
                alloc_oh[i] = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
    end

    assign full            = &busy;
    assign bus.issue_ready = !full;
    assign alloc_en        = bus.issue_valid && !full;
    assign disp_load       = !ex_valid_q || bus.ex_ready;
    assign disp_take       = disp_load && (|grant);
    assign dealloc         = disp_take ? grant : '0;

    rs_age_matrix #(.N(ENTRIES)) u_age (
        .clk      (clk),
        .rst      (rst),
        .flush    (rollback),
        .alloc_en (alloc_en),
        .alloc_oh (alloc_oh),
        .valid    (busy),
        .dealloc  (dealloc),
        .req      (ready),
        .grant    (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_vj_q    <= '0;
            ex_vk_q    <= '0;
            ex_dest_q  <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                op_q[i]   <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                dest_q[i] <= '0;
            end
        end else if (rollback) begin
            busy       <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (busy[i] && wake_j[i][DATA_W]) begin
                    vj_q[i] <= wake_j[i][DATA_W-1:0];
                    qj_q[i] <= '0;
                end
                if (busy[i] && wake_k[i][DATA_W]) begin
                    vk_q[i] <= wake_k[i][DATA_W-1:0];
                    qk_q[i] <= '0;
                end
            end
            // The allocated slot is free in registered busy, so it never collides with wakeup or dispatch
            if (alloc_en) begin
                busy[alloc_idx]   <= 1'b1;
                op_q[alloc_idx]   <= bus.issue_op;
                vj_q[alloc_idx]   <= byp_j[DATA_W] ? byp_j[DATA_W-1:0] : bus.issue_vj;
                vk_q[alloc_idx]   <= byp_k[DATA_W] ? byp_k[DATA_W-1:0] : bus.issue_vk;
                qj_q[alloc_idx]   <= byp_j[DATA_W] ? '0 : bus.issue_qj;
                qk_q[alloc_idx]   <= byp_k[DATA_W] ? '0 : bus.issue_qk;
                dest_q[alloc_idx] <= bus.issue_dest;
            end
            if (disp_load) begin
                ex_valid_q <= disp_take;
                if (disp_take) begin
                    busy[grant_idx] <= 1'b0;
                    ex_op_q         <= op_q[grant_idx];
                    ex_vj_q         <= vj_q[grant_idx];
                    ex_vk_q         <= vk_q[grant_idx];
                    ex_dest_q       <= dest_q[grant_idx];
                end
            end
        end
    end

    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_op    = ex_op_q;
    assign bus.ex_vj    = ex_vj_q;
    assign bus.ex_vk    = ex_vk_q;
    assign bus.ex_dest  = ex_dest_q;

endmodule

// File: tb/tb_rs_alu_multi.sv
// Directed scoreboard bench for rs_alu_multi: stimulus queues expected
// dispatches, a negedge monitor checks every ALU handshake against them.
module tb_rs_alu_multi;
    import rs_alu_multi_pkg::*;

    localparam int ENTRIES = 4;
    localparam int NCDB    = 2;
    localparam int ROB_W   = 4;
    localparam int DATA_W  = 32;
    localparam int OP_W    = 4;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [ROB_W-1:0]  dest;
    } disp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   rollback;
    logic [NCDB*ROB_W-1:0]  cdb_tag;
    logic [NCDB*DATA_W-1:0] cdb_data;
    logic                   full;
    logic [2:0]             count;

    disp_t sb[$];
    disp_t got, want, held;
    int    n_vec  = 0;
    int    n_miss = 0;

    rs_alu_multi_if #(.ROB_W(ROB_W), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    rs_alu_multi #(
        .ENTRIES (ENTRIES),
        .NCDB    (NCDB),
        .ROB_W   (ROB_W),
        .DATA_W  (DATA_W),
        .OP_W    (OP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rollback (rollback),
        .bus      (bus),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data),
        .full     (full),
        .count    (count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.ex_valid && bus.ex_ready) begin
            got = {bus.ex_op, bus.ex_vj, bus.ex_vk, bus.ex_dest};
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL dispatch_unexpected: got op=%0h vj=%h vk=%h dest=%0h, expected no dispatch",
                         got.op, got.vj, got.vk, got.dest);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    n_miss++;
                    $display("FAIL dispatch: got op=%0h vj=%h vk=%h dest=%0h, expected op=%0h vj=%h vk=%h dest=%0h",
                             got.op, got.vj, got.vk, got.dest, want.op, want.vj, want.vk, want.dest);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_disp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] vj,
                               input logic [DATA_W-1:0] vk, input logic [ROB_W-1:0] dest);
        sb.push_back({op, vj, vk, dest});
    endtask

    task automatic set_cdb(input int unsigned port, input logic [ROB_W-1:0] tag,
                           input logic [DATA_W-1:0] data);
        cdb_tag[port*ROB_W +: ROB_W]    = tag;
        cdb_data[port*DATA_W +: DATA_W] = data;
    endtask

    task automatic clr_cdb();
        cdb_tag  = '0;
        cdb_data = '0;
    endtask

    // Drives one issue request across a single clock edge; called at edge+1
    task automatic issue(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] vj,
                         input logic [DATA_W-1:0] vk, input logic [ROB_W-1:0] qj,
                         input logic [ROB_W-1:0] qk, input logic [ROB_W-1:0] dest);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_vj    = vj;
        bus.issue_vk    = vk;
        bus.issue_qj    = qj;
        bus.issue_qk    = qk;
        bus.issue_dest  = dest;
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int unsigned k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL %s_drain: got %0d outstanding dispatches, expected 0", name, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        rollback        = 1'b0;
        cdb_tag         = '0;
        cdb_data        = '0;
        bus.issue_valid = 1'b0;
        bus.issue_op    = '0;
        bus.issue_vj    = '0;
        bus.issue_vk    = '0;
        bus.issue_qj    = '0;
        bus.issue_qk    = '0;
        bus.issue_dest  = '0;
        bus.ex_ready    = 1'b0;
        #2;
        chk("rst_count", 64'(count), 0);
        chk("rst_full", 64'(full), 0);
        chk("rst_issue_ready", 64'(bus.issue_ready), 1);
        chk("rst_ex_valid", 64'(bus.ex_valid), 0);
        chk("rst_ex_fields", 64'({bus.ex_op, bus.ex_dest, bus.ex_vj | bus.ex_vk}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Ready issue: one-cycle latency to the dispatch register
        bus.ex_ready = 1'b1;
        expect_disp(ALU_ADD, 32'd5, 32'd7, 4'd3);
        issue(ALU_ADD, 32'd5, 32'd7, 4'd0, 4'd0, 4'd3);
        chk("ready_count_after_issue", 64'(count), 1);
        chk("ready_ex_valid_not_yet", 64'(bus.ex_valid), 0);
        @(posedge clk);
        #1;
        chk("ready_ex_valid", 64'(bus.ex_valid), 1);
        chk("ready_ex_vj", 64'(bus.ex_vj), 5);
        chk("ready_ex_vk", 64'(bus.ex_vk), 7);
        chk("ready_ex_dest", 64'(bus.ex_dest), 3);
        wait_drain("ready");

        // Oldest-first: C goes first, then A, then B after tag 2 on port 1
        expect_disp(ALU_OR,  32'd3,  32'd4, 4'd7);
        expect_disp(ALU_SUB, 32'h10, 32'd1, 4'd5);
        expect_disp(ALU_AND, 32'h10, 32'd2, 4'd6);
        issue(ALU_SUB, 32'd0, 32'd1, 4'd2, 4'd0, 4'd5);
        issue(ALU_AND, 32'd0, 32'd2, 4'd2, 4'd0, 4'd6);
        issue(ALU_OR,  32'd3, 32'd4, 4'd0, 4'd0, 4'd7);
        set_cdb(1, 4'd2, 32'h10);
        @(posedge clk);
        #1;
        clr_cdb();
        chk("oldest_first_c", 64'(bus.ex_dest), 7);
        wait_drain("oldest");

        // Wakeup with two ports on the same tag: port 0 wins, ready one cycle later
        expect_disp(ALU_SLL, 32'h66, 32'd1, 4'd8);
        issue(ALU_SLL, 32'd0, 32'd1, 4'd6, 4'd0, 4'd8);
        set_cdb(0, 4'd6, 32'h66);
        set_cdb(1, 4'd6, 32'h77);
        @(posedge clk);
        #1;
        clr_cdb();
        chk("wake_not_same_cycle", 64'(bus.ex_valid), 0);
        @(posedge clk);
        #1;
        chk("wake_dispatched", 64'(bus.ex_valid), 1);
        wait_drain("wake_lowport");

        // Issue bypass on both operands from both CDB ports
        expect_disp(ALU_XOR, 32'hAA, 32'hBB, 4'd9);
        set_cdb(0, 4'd4, 32'hAA);
        set_cdb(1, 4'd5, 32'hBB);
        issue(ALU_XOR, 32'd0, 32'd0, 4'd4, 4'd5, 4'd9);
        clr_cdb();
        @(posedge clk);
        #1;
        chk("bypass_ex_valid", 64'(bus.ex_valid), 1);
        chk("bypass_ex_vj", 64'(bus.ex_vj), 32'hAA);
        chk("bypass_ex_vk", 64'(bus.ex_vk), 32'hBB);
        wait_drain("bypass");

        // Bypass with both ports on the same tag
        expect_disp(ALU_SRL, 32'h66, 32'd1, 4'd10);
        set_cdb(0, 4'd6, 32'h66);
        set_cdb(1, 4'd6, 32'h77);
        issue(ALU_SRL, 32'd0, 32'd1, 4'd6, 4'd0, 4'd10);
        clr_cdb();
        wait_drain("bypass_lowport");

        // Backpressure and full
        bus.ex_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            expect_disp(4'(i), 32'h100 + i, 32'h200 + i, 4'(i + 1));
            issue(4'(i), 32'h100 + i, 32'h200 + i, 4'd0, 4'd0, 4'(i + 1));
        end
        held = {bus.ex_op, bus.ex_vj, bus.ex_vk, bus.ex_dest};
        chk("bp_count", 64'(count), 4);
        chk("bp_full", 64'(full), 1);
        chk("bp_issue_ready", 64'(bus.issue_ready), 0);
        chk("bp_ex_valid", 64'(bus.ex_valid), 1);
        chk("bp_ex_dest_first", 64'(bus.ex_dest), 1);
        issue(4'd15, 32'hDEAD, 32'hBEEF, 4'd0, 4'd0, 4'd15);
        @(posedge clk);
        #1;
        chk("bp_ignored_count", 64'(count), 4);
        chk("bp_hold_stable", 64'({bus.ex_op, bus.ex_vj[27:0], bus.ex_dest}),
            64'({held.op, held.vj[27:0], held.dest}));
        bus.ex_ready = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("bp_throughput_empty", 64'(sb.size()), 0);
        chk("bp_end_ex_valid", 64'(bus.ex_valid), 0);
        chk("bp_end_count", 64'(count), 0);

        // Rollback colliding with issue and CDB hit
        bus.ex_ready = 1'b0;
        issue(ALU_ADD, 32'd1, 32'd1, 4'd0, 4'd0, 4'd10);
        issue(ALU_ADD, 32'd0, 32'd2, 4'd7, 4'd0, 4'd11);
        issue(ALU_ADD, 32'd0, 32'd3, 4'd7, 4'd0, 4'd12);
        chk("rb_pre_count", 64'(count), 2);
        rollback = 1'b1;
        set_cdb(0, 4'd7, 32'h77);
        issue(ALU_SUB, 32'd9, 32'd9, 4'd0, 4'd0, 4'd13);
        rollback = 1'b0;
        clr_cdb();
        chk("rb_count", 64'(count), 0);
        chk("rb_ex_valid", 64'(bus.ex_valid), 0);
        chk("rb_full", 64'(full), 0);
        chk("rb_issue_ready", 64'(bus.issue_ready), 1);
        bus.ex_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        expect_disp(ALU_SLT, 32'd21, 32'd22, 4'd14);
        issue(ALU_SLT, 32'd21, 32'd22, 4'd0, 4'd0, 4'd14);
        wait_drain("rb_after");

        // Asynchronous reset mid-stream
        bus.ex_ready = 1'b0;
        issue(ALU_ADD, 32'd1, 32'd2, 4'd0, 4'd0, 4'd1);
        issue(ALU_ADD, 32'd0, 32'd2, 4'd3, 4'd0, 4'd2);
        issue(ALU_ADD, 32'd0, 32'd3, 4'd3, 4'd0, 4'd3);
        issue(ALU_ADD, 32'd0, 32'd4, 4'd3, 4'd0, 4'd4);
        chk("ares_pre_count", 64'(count), 3);
        chk("ares_pre_ex_valid", 64'(bus.ex_valid), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("ares_count", 64'(count), 0);
        chk("ares_ex_valid", 64'(bus.ex_valid), 0);
        chk("ares_full", 64'(full), 0);
        chk("ares_issue_ready", 64'(bus.issue_ready), 1);
        chk("ares_ex_dest", 64'(bus.ex_dest), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("final_scoreboard_empty", 64'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
